// File: rtl/msg_stream_framer.sv
// Purpose: buffers an InBus word stream in a FIFO and emits framed words on OutBus
//          with Start/End/Mod markers, truncating messages longer than MaxMsgWords.
// Latency: 2 cycles from input accept to OutBus_Valid (FIFO empty, Ready high); 1 word/cycle.
// Backpressure: OutBus_Ready low holds the output slice; the FIFO fills, then InBus_DataAck drops.
// Optional feature macro: MSGPARSE_STATS_EN builds the statistics counters; otherwise Stat_* are 0.
// Ports: clk/reset (async, active low); InBus_* ingress word stream with DataAck;
//        OutBus_* framed egress stream with Ready; Stat_MsgCount/Stat_DropCount saturating counters.
module msg_stream_framer #(
  parameter int WordWidth     = 64,
  parameter int Bits          = 3,
  parameter int FifoDepthLog2 = 4,
  parameter int MaxMsgWords   = 256,
  parameter int CntWidth      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 InBus_DataValid,
  input  logic                 InBus_LastWord,
  input  logic [WordWidth-1:0] InBus_Data,
  input  logic [Bits-1:0]      InBus_DataMod,
  output logic                 InBus_DataAck,
  input  logic                 OutBus_Ready,
  output logic                 OutBus_Valid,
  output logic                 OutBus_Start_Msg,
  output logic                 OutBus_End_Msg,
  output logic [Bits-1:0]      OutBus_Mod,
  output logic [WordWidth-1:0] OutBus_Data,
  output logic                 OutBus_Error,
  output logic [CntWidth-1:0]  Stat_MsgCount,
  output logic [CntWidth-1:0]  Stat_DropCount
);

  localparam int Depth = 2 ** FifoDepthLog2;
  localparam int PtrW  = FifoDepthLog2 + 1;
  localparam int EntW  = WordWidth + Bits + 1;
  localparam int WcntW = $clog2(MaxMsgWords) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_IN_MSG, ST_DROP} state_t;

  logic [EntW-1:0]      mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 ack_q, ack_d;
  state_t               state_q, state_d;
  logic [WcntW-1:0]     wcnt_q, wcnt_d;
  logic                 vld_q, vld_d, start_q, start_d, end_q, end_d, err_q, err_d;
  logic [Bits-1:0]      mod_q, mod_d;
  logic [WordWidth-1:0] data_q, data_d;

  logic                 fifo_empty, wr_en, pop, nxt_full;
  logic [EntW-1:0]      rd_ent;
  logic                 rd_last;
  logic [Bits-1:0]      rd_mod;
  logic [WordWidth-1:0] rd_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign wr_en      = InBus_DataValid && ack_q;
  // DROP consumes words without using the output slice, so it ignores Ready.
  assign pop        = !fifo_empty && ((state_q == ST_DROP) || !vld_q || OutBus_Ready);

  assign rd_ent  = mem_q[rd_ptr_q[FifoDepthLog2-1:0]];
  assign rd_last = rd_ent[EntW-1];
  assign rd_mod  = rd_ent[WordWidth +: Bits];
  assign rd_data = rd_ent[WordWidth-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[FifoDepthLog2-1:0]] <= {InBus_LastWord, InBus_DataMod, InBus_Data};
    end
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    // Ack is registered from next-cycle occupancy, so it never depends on DataValid.
    nxt_full = (wr_ptr_d[PtrW-1] != rd_ptr_d[PtrW-1]) &&
               (wr_ptr_d[PtrW-2:0] == rd_ptr_d[PtrW-2:0]);
    ack_d    = !nxt_full;

    state_d = state_q;
    wcnt_d  = wcnt_q;
    vld_d   = vld_q;
    start_d = start_q;
    end_d   = end_q;
    err_d   = err_q;
    mod_d   = mod_q;
    data_d  = data_q;

    if (vld_q && OutBus_Ready) vld_d = 1'b0;

    if (pop) begin
      case (state_q)
        ST_IDLE: begin
          vld_d   = 1'b1;
          start_d = 1'b1;
          end_d   = rd_last;
          err_d   = 1'b0;
          mod_d   = rd_last ? rd_mod : '0;
          data_d  = rd_data;
          wcnt_d  = WcntW'(1);
          state_d = rd_last ? ST_IDLE : ST_IN_MSG;
        end
        ST_IN_MSG: begin
          vld_d   = 1'b1;
          start_d = 1'b0;
          data_d  = rd_data;
          wcnt_d  = wcnt_q + WcntW'(1);
          err_d   = 1'b0;
          end_d   = 1'b0;
          mod_d   = '0;
          if (rd_last) begin
            end_d   = 1'b1;
            mod_d   = rd_mod;
            state_d = ST_IDLE;
          end else if ((wcnt_q + WcntW'(1)) == WcntW'(MaxMsgWords)) begin
            // Length limit reached: close the message here as truncated.
            end_d   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (rd_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ack_q    <= 1'b0;
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      vld_q    <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
      mod_q    <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_q    <= ack_d;
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      vld_q    <= vld_d;
      start_q  <= start_d;
      end_q    <= end_d;
      err_q    <= err_d;
      mod_q    <= mod_d;
      data_q   <= data_d;
    end
  end

  assign InBus_DataAck    = ack_q;
  assign OutBus_Valid     = vld_q;
  assign OutBus_Start_Msg = start_q;
  assign OutBus_End_Msg   = end_q;
  assign OutBus_Error     = err_q;
  assign OutBus_Mod       = mod_q;
  assign OutBus_Data      = data_q;

`ifdef MSGPARSE_STATS_EN
  logic [CntWidth-1:0] msg_cnt_q, msg_cnt_d, drop_cnt_q, drop_cnt_d;

  // Both counters saturate at all-ones.
  always_comb begin
    msg_cnt_d  = msg_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (vld_q && OutBus_Ready && end_q && (msg_cnt_q != '1)) msg_cnt_d = msg_cnt_q + CntWidth'(1);
    if (pop && (state_q == ST_DROP) && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CntWidth'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      msg_cnt_q  <= msg_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Stat_MsgCount  = msg_cnt_q;
  assign Stat_DropCount = drop_cnt_q;
`else
  assign Stat_MsgCount  = '0;
  assign Stat_DropCount = '0;
`endif

endmodule

// File: tb/tb_msg_stream_framer.sv
// Purpose: scoreboard bench for msg_stream_framer; expected framing is computed per message.
// Latency: n/a.
// Backpressure: OutBus_Ready driven low, high or random per phase.
module tb_msg_stream_framer;

  localparam int WW = 64, BITS = 3, FLOG = 4, MAXW = 4, CW = 4;
  localparam int SatMax = 2 ** CW - 1;
`ifdef MSGPARSE_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            InBus_DataValid, InBus_LastWord, InBus_DataAck;
  logic [WW-1:0]   InBus_Data;
  logic [BITS-1:0] InBus_DataMod;
  logic            OutBus_Ready, OutBus_Valid, OutBus_Start_Msg, OutBus_End_Msg, OutBus_Error;
  logic [BITS-1:0] OutBus_Mod;
  logic [WW-1:0]   OutBus_Data;
  logic [CW-1:0]   Stat_MsgCount, Stat_DropCount;

  always #5 clk = ~clk;

  msg_stream_framer #(
    .WordWidth(WW), .Bits(BITS), .FifoDepthLog2(FLOG), .MaxMsgWords(MAXW), .CntWidth(CW)
  ) dut (
    .clk(clk), .reset(rst_n),
    .InBus_DataValid(InBus_DataValid), .InBus_LastWord(InBus_LastWord),
    .InBus_Data(InBus_Data), .InBus_DataMod(InBus_DataMod), .InBus_DataAck(InBus_DataAck),
    .OutBus_Ready(OutBus_Ready), .OutBus_Valid(OutBus_Valid),
    .OutBus_Start_Msg(OutBus_Start_Msg), .OutBus_End_Msg(OutBus_End_Msg),
    .OutBus_Mod(OutBus_Mod), .OutBus_Data(OutBus_Data), .OutBus_Error(OutBus_Error),
    .Stat_MsgCount(Stat_MsgCount), .Stat_DropCount(Stat_DropCount)
  );

  typedef struct packed {
    logic [WW-1:0]   data;
    logic            start;
    logic            endm;
    logic [BITS-1:0] mod;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_errs = 0;
  int   exp_msgs = 0, exp_drops = 0, acc_cnt = 0;
  int   rdy_mode = 0;
  int   wt;
  logic held = 1'b0;
  exp_t held_val, mon_cur, mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int stat_exp(input int v);
    if (!StatsEn) return 0;
    return (v > SatMax) ? SatMax : v;
  endfunction

  // Ready driver, changed just after each rising edge.
  initial begin
    OutBus_Ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       OutBus_Ready = 1'b0;
        1:       OutBus_Ready = 1'b1;
        default: OutBus_Ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: transfers complete at the next rising edge after a falling-edge sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      mon_cur.data  = OutBus_Data;
      mon_cur.start = OutBus_Start_Msg;
      mon_cur.endm  = OutBus_End_Msg;
      mon_cur.mod   = OutBus_Mod;
      mon_cur.err   = OutBus_Error;
      if (held) chk("hold_stable", {OutBus_Valid, mon_cur}, {1'b1, held_val});
      if (OutBus_Valid && OutBus_Ready) begin
        if (exp_q.size() == 0) begin
          chk("out_with_empty_scoreboard", OutBus_Valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", OutBus_Data, mon_e.data);
          chk("out_flags_start_end_mod_err",
              {OutBus_Start_Msg, OutBus_End_Msg, OutBus_Mod, OutBus_Error},
              {mon_e.start, mon_e.endm, mon_e.mod, mon_e.err});
        end
      end
      held     = OutBus_Valid && !OutBus_Ready;
      held_val = mon_cur;
      if (InBus_DataValid && InBus_DataAck) acc_cnt++;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send_word(input logic [WW-1:0] d, input logic last, input logic [BITS-1:0] mod);
    int t = 0;
    InBus_DataValid = 1'b1;
    InBus_Data      = d;
    InBus_LastWord  = last;
    InBus_DataMod   = mod;
    @(negedge clk);
    while (!InBus_DataAck && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!InBus_DataAck) chk("ack_wait_timeout", InBus_DataAck, 1);
    @(posedge clk);
    #1;
    InBus_DataValid = 1'b0;
    InBus_LastWord  = 1'b0;
  endtask

  // Reference framing: at most MAXW words emitted; overlong messages end on word MAXW
  // with Error set and Mod 0, and the remaining words are counted as dropped.
  task automatic send_msg(input int n, input logic [BITS-1:0] mod, input logic [WW-1:0] base,
                          input bit push);
    exp_t          e;
    logic [WW-1:0] words[$];
    for (int i = 0; i < n; i++)
      words.push_back((base != 0) ? base + WW'(i) : {$urandom(), $urandom()});
    if (push) begin
      for (int i = 0; i < n && i < MAXW; i++) begin
        e.data  = words[i];
        e.start = (i == 0);
        if (n <= MAXW) begin
          e.endm = (i == n - 1);
          e.err  = 1'b0;
          e.mod  = e.endm ? mod : '0;
        end else begin
          e.endm = (i == MAXW - 1);
          e.err  = e.endm;
          e.mod  = '0;
        end
        exp_q.push_back(e);
      end
      exp_msgs++;
      if (n > MAXW) exp_drops += n - MAXW;
    end
    for (int i = 0; i < n; i++)
      send_word(words[i], (i == n - 1), (i == n - 1) ? mod : BITS'($urandom_range(0, 7)));
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || OutBus_Valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_words_left"}, exp_q.size(), 0);
    repeat (20) @(negedge clk);
    chk({tag, "_msg_count"}, Stat_MsgCount, stat_exp(exp_msgs));
    chk({tag, "_drop_count"}, Stat_DropCount, stat_exp(exp_drops));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    InBus_DataValid = 1'b0;
    InBus_LastWord  = 1'b0;
    InBus_Data      = '0;
    InBus_DataMod   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", InBus_DataAck, 0);
    chk("rst_valid", OutBus_Valid, 0);
    chk("rst_flags", {OutBus_Start_Msg, OutBus_End_Msg, OutBus_Mod, OutBus_Error}, 0);
    chk("rst_data", OutBus_Data, 0);
    chk("rst_stats", {Stat_MsgCount, Stat_DropCount}, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;

    // Single-word message and minimum latency.
    send_msg(1, 3'd3, 64'hA5, 1'b1);
    @(negedge clk);
    chk("latency_n1_valid", OutBus_Valid, 0);
    @(negedge clk);
    chk("latency_n2_valid", OutBus_Valid, 1);
    drain("single");

    // Four-word message, back to back.
    fork
      send_msg(4, 3'd0, 64'd1, 1'b1);
      begin
        wt = 0;
        @(negedge clk);
        while (!OutBus_Valid && wt < 50) begin
          @(negedge clk);
          wt++;
        end
        chk("burst_valid_1", OutBus_Valid, 1);
        for (int k = 2; k <= 4; k++) begin
          @(negedge clk);
          chk("burst_valid_consecutive", OutBus_Valid, 1);
        end
        @(negedge clk);
        chk("burst_valid_after", OutBus_Valid, 0);
      end
    join
    drain("four_word");

    // Truncation of a 7-word message, then a clean follow-up message.
    send_msg(7, 3'd5, 64'h100, 1'b1);
    send_msg(1, 3'd2, 64'h200, 1'b1);
    drain("truncate");

    // Output held off: 16 in FIFO plus 1 in the output slice.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    acc_cnt = 0;
    fork
      for (int i = 0; i < 20; i++) send_msg(1, BITS'(i), 64'h1000 + WW'(i), 1'b1);
      begin
        repeat (40) @(negedge clk);
        chk("bp_words_accepted", acc_cnt, 17);
        chk("bp_ack_low", InBus_DataAck, 0);
        chk("bp_out_valid", OutBus_Valid, 1);
        chk("bp_out_first_word", OutBus_Data, 64'h1000);
        rdy_mode = 1;
      end
    join
    drain("backpressure");

    // Asynchronous reset mid-message: one word in the slice, five in the FIFO.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send_word(64'h3000 + WW'(i), 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", OutBus_Valid, 0);
    chk("arst_flags", {OutBus_Start_Msg, OutBus_End_Msg, OutBus_Mod, OutBus_Error}, 0);
    chk("arst_data", OutBus_Data, 0);
    chk("arst_ack", InBus_DataAck, 0);
    chk("arst_stats", {Stat_MsgCount, Stat_DropCount}, 0);
    exp_q.delete();
    exp_msgs  = 0;
    exp_drops = 0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle_valid", OutBus_Valid, 0);
    send_msg(3, 3'd6, 64'h4000, 1'b1);
    drain("post_reset");

    // Randomized messages with random backpressure and idle gaps.
    rdy_mode = 2;
    for (int m = 0; m < 150; m++) begin
      send_msg($urandom_range(1, 7), BITS'($urandom_range(0, 7)), '0, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain("random");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/msg_stream_framer.md
Name: msg_stream_framer

Overview:
Parametrised successor to the message-parsing top level. It replaces the block1 → fifo → block2 → datapath chain with a single framer that has a configurable FIFO depth, output backpressure, and maximum-length enforcement. The framer accepts the InBus word stream, buffers it, and emits framed words on OutBus with Start/End/Mod markers and an oversize error flag. It sits between the line-side word source and the downstream message decoder.

Parameters:
WordWidth, 64, data word width in bits (multiple of 8)
Bits, 3, width of Mod field; equals log2(WordWidth/8)
FifoDepthLog2, 4, FIFO depth = 2**FifoDepthLog2 entries
MaxMsgWords, 256, maximum words per message before truncation (≥2)
CntWidth, 16, width of statistics counters

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
InBus_DataValid  in  1  source presents a word
InBus_LastWord  in  1  current word ends the message
InBus_Data  in  WordWidth  message word
InBus_DataMod  in  Bits  valid bytes in last word; 0 = all bytes valid
InBus_DataAck  out  1  word accepted this cycle when high with DataValid
OutBus_Ready  in  1  downstream accepts output word
OutBus_Valid  out  1  output word valid
OutBus_Start_Msg  out  1  first word of message
OutBus_End_Msg  out  1  last word of message
OutBus_Mod  out  Bits  valid bytes on End word; 0 elsewhere
OutBus_Data  out  WordWidth  output word
OutBus_Error  out  1  message truncated; valid with End_Msg
Stat_MsgCount  out  CntWidth  messages completed on OutBus
Stat_DropCount  out  CntWidth  input words discarded by truncation

Behaviour:
- Reset (reset=0, async): FIFO empty, pointers 0, FSM in IDLE, all outputs 0, counters 0. InBus_DataAck is 0 while reset is asserted. A reset during a message abandons the message; no End_Msg is emitted for it.
- Ingress:
  - InBus_DataAck = !fifo_full, driven from registered occupancy only (no combinational path from InBus_DataValid).
  - A word is written when DataValid && DataAck. The FIFO entry is {LastWord, DataMod, Data}.
  - Simultaneous read and write at full: the write is refused because Ack is already low. Simultaneous read and write at empty: the write proceeds, and the read sees the entry no earlier than the next cycle.
- FIFO: pointers are FifoDepthLog2+1 bits wide and wrap modulo 2**(FifoDepthLog2+1). full/empty are derived from pointer MSB compare.
- Output stage: a single register slice.
  - It loads from the FIFO when the FIFO is not empty and (!OutBus_Valid || OutBus_Ready).
  - While Valid && !Ready, all OutBus signals hold stable.
  - Minimum latency: a word accepted at cycle N appears on OutBus_Valid at N+2, given FIFO empty and Ready=1.
  - Full throughput is one word per cycle.
- FSM (advances on each FIFO pop), with a word counter wcnt (log2(MaxMsgWords)+1 bits):
  - IDLE: the popped word is emitted with Start_Msg=1 and wcnt=1. If last=1, End_Msg=1 is also set (single-word message) and the FSM stays in IDLE. Otherwise the FSM goes to IN_MSG.
  - IN_MSG: emit the word and increment wcnt.
    - last=1: End_Msg=1, Mod=entry Mod, go to IDLE.
    - last=0 and wcnt+1 == MaxMsgWords: End_Msg=1, Error=1, Mod=0, go to DROP.
  - DROP: pop words without emitting them, incrementing Stat_DropCount for each. On a word with last=1, go to IDLE. In DROP, popping ignores OutBus_Ready.
- Mod is forced to 0 on non-End words. Start_Msg and End_Msg are meaningful only with Valid.
- Stat_MsgCount increments on each accepted output word with End_Msg=1, including truncated messages. Counters saturate at all-ones (no wrap).

Optional Feature:
MSGPARSE_STATS_EN
- Defined: Stat_MsgCount and Stat_DropCount are implemented as described above.
- Undefined: no counter registers are built; both Stat ports are tied to 0. All other behaviour is identical.

Test Plan:
- Reset then a single-word message: Data=0xA5, LastWord=1, Mod=3, Ready=1 → at N+2 Valid=1, Start=1, End=1, Mod=3, Error=0; Stat_MsgCount=1.
- 4-word message, Ready=1, words 1..4, Mod=0 → Start only on word 1, End only on word 4, Mod=0 on all words, 4 consecutive Valid cycles.
- Ready held 0 with 20 words offered, FifoDepthLog2=4 → Ack drops after 16 accepted words plus 1 word held in the output register; OutBus stays stable. On Ready=1, all 17 words drain in order with no loss.
- MaxMsgWords=4, 7-word message with LastWord on word 7 → word 4 emitted with End=1, Error=1, Mod=0; words 5-7 dropped; Stat_DropCount=3. The next message starts cleanly with Start=1.
- Async reset asserted mid-message with the FIFO holding 5 words → all outputs immediately 0, FIFO empty. After release, a new message frames correctly and the abandoned message never produces an End.
- Build without MSGPARSE_STATS_EN, run the truncation test → Stat ports remain 0 and framing output is identical to the build with the macro defined.
